// File: rtl/dma_seq.sv
// dma_seq -- single-channel DMA run sequencer.
//
// The CPU loads four registers while the channel is idle:
//   AC  address counter, WC word counter, WR word register, CR termination mode.
// A start pulse launches a run. Each word is requested on the bus (REQ) and,
// once acknowledged, both counters advance. The following cycle (CHECK)
// samples the external terminal-count flag. If the flag is set, a one-cycle
// completion pulse (FIN) follows. An abort drops the run immediately.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      CPU register write strobe (honoured only in IDLE)
//   wr_sel     write target: 00 AC, 01 WC, 10 WR, 11 CR
//   din        write data (CR takes din[1:0])
//   start      single-cycle run request
//   abort      terminates an active run
//   xfer_ack   bus acknowledge for the current word
//   done       terminal-count flag from the downstream done generator
//   AC/WC/WR   8-bit registers
//   CR         2-bit termination mode
//   WCin       sticky word-counter carry, cleared by each start
//   xfer_req   bus transfer request (REQ state)
//   busy       run active (REQ or CHECK)
//   irq        one-cycle completion pulse (FIN state)

module dma_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [1:0] wr_sel,
   input  logic [7:0] din,
   input  logic       start,
   input  logic       abort,
   input  logic       xfer_ack,
   input  logic       done,
   output logic [7:0] AC,
   output logic [7:0] WC,
   output logic [7:0] WR,
   output logic [1:0] CR,
   output logic       WCin,
   output logic       xfer_req,
   output logic       busy,
   output logic       irq
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      CHECK = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] ac_nxt;
   logic [7:0] wc_nxt;
   logic [7:0] wr_nxt;
   logic [1:0] cr_nxt;
   logic       wcin_nxt;

   // State and register bank. Reset clears everything at once, so a run
   // interrupted by reset leaves no trace and cannot produce an irq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         AC    <= 8'h00;
         WC    <= 8'h00;
         WR    <= 8'h00;
         CR    <= 2'b00;
         WCin  <= 1'b0;
      end else begin
         state <= state_nxt;
         AC    <= ac_nxt;
         WC    <= wc_nxt;
         WR    <= wr_nxt;
         CR    <= cr_nxt;
         WCin  <= wcin_nxt;
      end
   end

   // Next-state and register update logic. The handshake outputs are
   // decoded purely from the state, so they drop as soon as the state
   // register is reset. Abort is tested before ack/done so that an aborted
   // cycle never advances the counters.
   always_comb begin
      state_nxt = state;
      ac_nxt    = AC;
      wc_nxt    = WC;
      wr_nxt    = WR;
      cr_nxt    = CR;
      wcin_nxt  = WCin;
      xfer_req  = 1'b0;
      busy      = 1'b0;
      irq       = 1'b0;

      case (state)
         IDLE: begin
            // A write wins over a simultaneous start.
            if (wr_en) begin
               case (wr_sel)
                  2'b00:   ac_nxt = din;
                  2'b01:   wc_nxt = din;
                  2'b10:   wr_nxt = din;
                  default: cr_nxt = din[1:0];
               endcase
            end else if (start) begin
               wcin_nxt  = 1'b0;
               state_nxt = REQ;
            end
         end

         REQ: begin
            xfer_req = 1'b1;
            busy     = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else if (xfer_ack) begin
               ac_nxt = AC + 8'd1;
               wc_nxt = WC + 8'd1;
               // Carry is sticky: only a wrap sets it, nothing in the run clears it.
               if (WC == 8'hFF) begin
                  wcin_nxt = 1'b1;
               end
               state_nxt = CHECK;
            end
         end

         CHECK: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
            end else if (done) begin
               state_nxt = FIN;
            end else begin
               state_nxt = REQ;
            end
         end

         FIN: begin
            irq       = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dma_seq.sv
// tb_dma_seq -- directed self-checking bench for dma_seq.
//
// The downstream done generator is modelled here from the DUT's registered
// outputs: mode 00 ends on carry, 01 when WC+1 equals WR, 10 when WC equals
// WR, and 11 never. Inputs are driven and outputs sampled 1 ns after each
// rising edge.

module tb_dma_seq;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] wr_sel;
   logic [7:0] din;
   logic       start;
   logic       abort;
   logic       xfer_ack;
   logic       done;
   logic [7:0] AC;
   logic [7:0] WC;
   logic [7:0] WR;
   logic [1:0] CR;
   logic       WCin;
   logic       xfer_req;
   logic       busy;
   logic       irq;

   int assert_count;
   int fail_count;

   logic [7:0] wc_plus;
   logic [7:0] exp_wc;
   logic       saw_irq;

   dma_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .din      (din),
      .start    (start),
      .abort    (abort),
      .xfer_ack (xfer_ack),
      .done     (done),
      .AC       (AC),
      .WC       (WC),
      .WR       (WR),
      .CR       (CR),
      .WCin     (WCin),
      .xfer_req (xfer_req),
      .busy     (busy),
      .irq      (irq)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream done generator model.
   always_comb begin
      wc_plus = WC + 8'd1;
      case (CR)
         2'b00:   done = WCin;
         2'b01:   done = (wc_plus == WR);
         2'b10:   done = (WC == WR);
         default: done = 1'b0;
      endcase
   end

   // Drive one cycle of inputs, then return 1 ns after the edge that used them.
   task automatic applyStimulus(input logic we, input logic [1:0] sel, input logic [7:0] data,
                                input logic st, input logic ab, input logic ack);
      wr_en    = we;
      wr_sel   = sel;
      din      = data;
      start    = st;
      abort    = ab;
      xfer_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      assert_count = 0;
      fail_count   = 0;
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_sel   = 2'b00;
      din      = 8'h00;
      start    = 1'b0;
      abort    = 1'b0;
      xfer_ack = 1'b0;

      // Reset state.
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_AC", AC, 8'h00);
      checkOutput("rst_WC", WC, 8'h00);
      checkOutput("rst_WR", WR, 8'h00);
      checkOutput("rst_CR", {6'd0, CR}, 8'h00);
      checkBit("rst_WCin", WCin, 1'b0);
      checkBit("rst_busy", busy, 1'b0);
      checkBit("rst_xfer_req", xfer_req, 1'b0);
      checkBit("rst_irq", irq, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      checkBit("rel_irq", irq, 1'b0);
      checkBit("rel_xfer_req", xfer_req, 1'b0);

      // Mode 00: run until the word counter wraps.
      $display("[TB] mode 00 carry run");
      applyStimulus(1, 2'b00, 8'h10, 0, 0, 0);
      checkOutput("wr_AC", AC, 8'h10);
      applyStimulus(1, 2'b01, 8'hFC, 0, 0, 0);
      checkOutput("wr_WC", WC, 8'hFC);
      applyStimulus(1, 2'b10, 8'h00, 0, 0, 0);
      applyStimulus(1, 2'b11, 8'h00, 0, 0, 0);
      checkOutput("wr_CR", {6'd0, CR}, 8'h00);
      applyStimulus(0, 2'b00, 8'h00, 1, 0, 0);
      checkBit("m0_req", xfer_req, 1'b1);
      checkBit("m0_busy", busy, 1'b1);
      exp_wc = 8'hFC;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 2'b00, 8'h00, 0, 0, 1);
         exp_wc = exp_wc + 8'd1;
         checkOutput("m0_WC", WC, exp_wc);
         checkBit("m0_WCin", WCin, (i == 4));
         checkBit("m0_check_busy", busy, 1'b1);
         applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
         checkBit("m0_irq", irq, (i == 4));
         checkBit("m0_next_req", xfer_req, (i != 4));
      end
      checkBit("m0_fin_busy", busy, 1'b0);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      checkBit("m0_irq_end", irq, 1'b0);
      checkOutput("m0_AC", AC, 8'h14);
      checkOutput("m0_WC_end", WC, 8'h00);

      // Mode 01: stop when WC+1 == WR.
      $display("[TB] mode 01 match run");
      applyStimulus(1, 2'b11, 8'h01, 0, 0, 0);
      applyStimulus(1, 2'b10, 8'h05, 0, 0, 0);
      applyStimulus(1, 2'b01, 8'h02, 0, 0, 0);
      applyStimulus(0, 2'b00, 8'h00, 1, 0, 0);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 1);
      checkOutput("m1_WC1", WC, 8'h03);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      checkBit("m1_irq1", irq, 1'b0);
      checkBit("m1_req2", xfer_req, 1'b1);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 1);
      checkOutput("m1_WC2", WC, 8'h04);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      checkBit("m1_irq2", irq, 1'b1);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      checkBit("m1_irq_end", irq, 1'b0);
      checkBit("m1_busy_end", busy, 1'b0);
      checkOutput("m1_WC_end", WC, 8'h04);

      // Stalled REQ, then mode 11 long run ended by abort.
      $display("[TB] stall and mode 11 run");
      applyStimulus(1, 2'b11, 8'h03, 0, 0, 0);
      applyStimulus(1, 2'b00, 8'h00, 0, 0, 0);
      applyStimulus(1, 2'b01, 8'h00, 0, 0, 0);
      applyStimulus(0, 2'b00, 8'h00, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
         checkBit("stall_req", xfer_req, 1'b1);
      end
      checkOutput("stall_AC", AC, 8'h00);
      checkOutput("stall_WC", WC, 8'h00);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 1);
      checkOutput("stall_ack_AC", AC, 8'h01);
      checkOutput("stall_ack_WC", WC, 8'h01);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      saw_irq = 1'b0;
      for (int i = 1; i < 300; i++) begin
         applyStimulus(0, 2'b00, 8'h00, 0, 0, 1);
         saw_irq = saw_irq | irq;
         applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
         saw_irq = saw_irq | irq;
      end
      checkBit("m3_no_irq", saw_irq, 1'b0);
      checkOutput("m3_AC", AC, 8'h2C);
      checkOutput("m3_WC", WC, 8'h2C);
      checkBit("m3_WCin", WCin, 1'b1);
      checkBit("m3_req", xfer_req, 1'b1);
      applyStimulus(0, 2'b00, 8'h00, 0, 1, 1);
      checkBit("abort_busy", busy, 1'b0);
      checkBit("abort_irq", irq, 1'b0);
      checkBit("abort_req", xfer_req, 1'b0);
      checkOutput("abort_AC", AC, 8'h2C);
      checkOutput("abort_WC", WC, 8'h2C);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      checkBit("abort_irq_after", irq, 1'b0);

      // Writes while busy are ignored; write beats start in IDLE.
      $display("[TB] write gating");
      applyStimulus(0, 2'b00, 8'h00, 1, 0, 0);
      applyStimulus(1, 2'b10, 8'hAA, 0, 0, 0);
      checkOutput("busy_wr_WR", WR, 8'h05);
      checkBit("busy_wr_busy", busy, 1'b1);
      applyStimulus(0, 2'b00, 8'h00, 0, 1, 0);
      checkBit("busy_abort", busy, 1'b0);
      applyStimulus(1, 2'b10, 8'h3C, 1, 0, 0);
      checkOutput("wr_start_WR", WR, 8'h3C);
      checkBit("wr_start_busy", busy, 1'b0);
      checkBit("wr_start_req", xfer_req, 1'b0);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
      checkBit("wr_start_idle", busy, 1'b0);

      // Reset pulsed mid-run between clock edges.
      $display("[TB] mid-run reset");
      applyStimulus(0, 2'b00, 8'h00, 1, 0, 0);
      applyStimulus(0, 2'b00, 8'h00, 0, 0, 1);
      checkBit("mid_busy_pre", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_AC", AC, 8'h00);
      checkOutput("mid_WC", WC, 8'h00);
      checkOutput("mid_WR", WR, 8'h00);
      checkOutput("mid_CR", {6'd0, CR}, 8'h00);
      checkBit("mid_WCin", WCin, 1'b0);
      checkBit("mid_busy", busy, 1'b0);
      checkBit("mid_req", xfer_req, 1'b0);
      checkBit("mid_irq", irq, 1'b0);
      wr_en    = 1'b0;
      start    = 1'b0;
      xfer_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      saw_irq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 2'b00, 8'h00, 0, 0, 0);
         saw_irq = saw_irq | irq | busy | xfer_req;
      end
      checkBit("mid_quiet", saw_irq, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
